task3_bin2seg: RTL and testbench



---
 rtl/task3_bin2seg.sv | 99 +++++++++
 tb/tb_task3_bin2seg.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/task3_bin2seg.sv
// ---------------------------------------------------------------------------
// task3_bin2seg
// Converts a 4-bit unsigned value {B3,B2,B1,B0} (0..15) into two decimal
// digits (tens, units) and drives both as seven-segment patterns.
//   num[13:7] = tens digit, num[6:0] = units digit, bit order {g,f,e,d,c,b,a}.
// The output is registered, so num shows the value sampled one rising edge
// earlier. There is no combinational path from the inputs to num.
// ACTIVE_LOW = 1 : segment lit when its bit is 0 (DE-board style).
// ACTIVE_LOW = 0 : every pattern is inverted, so segment lit when bit is 1.
// Optional build macro LEADING_ZERO_BLANK_EN: when defined, the tens digit
// is blanked for values below 10 instead of showing "0".
// ---------------------------------------------------------------------------
module task3_bin2seg #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        B3,
  input  logic        B2,
  input  logic        B1,
  input  logic        B0,
  output logic [13:0] num
);

  // All segments off, in the polarity selected by ACTIVE_LOW.
  localparam logic [13:0] ALL_OFF = ACTIVE_LOW ? 14'h3FFF : 14'h0000;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  logic [3:0]  w_v;
  logic        w_tens;
  logic [3:0]  w_units;
  logic [6:0]  w_tens_seg;
  logic [6:0]  w_units_seg;
  logic [13:0] w_num;
  logic [13:0] r_num;

  assign w_v = {B3, B2, B1, B0};

  // Active-low segment pattern for one decimal digit; codes 10..15 cannot
  // occur after the BCD split, so they are mapped to blank.
  function automatic logic [6:0] seg_lo(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  // BCD split by one compare and one subtract, then segment encoding.
  always_comb begin
    // NOTE: every signal gets a value before any branch, so no latch can be inferred.
    w_tens      = 1'b0;
    w_units     = w_v;
    w_tens_seg  = SEG_BLANK;
    w_units_seg = SEG_BLANK;
    w_num       = ALL_OFF;

    if (w_v >= 4'd10) begin
      w_tens  = 1'b1;
      w_units = w_v - 4'd10;
    end

`ifdef LEADING_ZERO_BLANK_EN
    w_tens_seg = w_tens ? seg_lo(4'd1) : SEG_BLANK;
`else
    w_tens_seg = seg_lo({3'b000, w_tens});
`endif
    w_units_seg = seg_lo(w_units);

    w_num = {w_tens_seg, w_units_seg};
    if (!ACTIVE_LOW) begin
      w_num = ~w_num;
    end
  end

  // Output register: reset blanks the display immediately, each edge loads
  // the conversion of the inputs present at that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!rst_n) begin
      r_num <= ALL_OFF;
    end else begin
      r_num <= w_num;
    end
  end

  assign num = r_num;

endmodule

// File: tb/tb_task3_bin2seg.sv
// ---------------------------------------------------------------------------
// tb_task3_bin2seg
// Directed plus random stimulus for task3_bin2seg. Two instances share the
// inputs: one with ACTIVE_LOW=1, one with ACTIVE_LOW=0. Expected values come
// from a decimal-digit model (v/10, v%10, digit lookup). Honours the
// LEADING_ZERO_BLANK_EN macro the same way as the design build.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_task3_bin2seg;

  logic        clk;
  logic        rst_n;
  logic        b3, b2, b1, b0;
  logic [13:0] num_lo;
  logic [13:0] num_hi;

  int vectors;
  int miscompares;

  // Active-low seven-segment shapes of decimal digits 0..9, {g,f,e,d,c,b,a}.
  localparam logic [6:0] DIGIT_SHAPE [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  task3_bin2seg #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .B3(b3), .B2(b2), .B1(b1), .B0(b0), .num(num_lo)
  );

  task3_bin2seg #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .B3(b3), .B2(b2), .B1(b1), .B0(b0), .num(num_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: display image for value v in active-low polarity.
  function automatic logic [13:0] model_lo(input int v);
    int         tens;
    int         units;
    logic [6:0] tens_seg;
    tens  = v / 10;
    units = v % 10;
    tens_seg = DIGIT_SHAPE[tens];
`ifdef LEADING_ZERO_BLANK_EN
    if (tens == 0) tens_seg = 7'h7F;
`endif
    return {tens_seg, DIGIT_SHAPE[units]};
  endfunction

  task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_v(input int v);
    logic [3:0] bits;
    bits = 4'(v);
    {b3, b2, b1, b0} = bits;
  endtask

  // Apply v at a falling edge, confirm the outputs do not move before the
  // next rising edge, then check the converted value just after it.
  task automatic apply(input int v, input logic [13:0] prev_lo, input string tag);
    @(negedge clk);
    set_v(v);
    #1;
    check({tag, "_hold_lo"}, num_lo, prev_lo);
    check({tag, "_hold_hi"}, num_hi, ~prev_lo);
    @(posedge clk);
    #1;
    check({tag, "_lo"}, num_lo, model_lo(v));
    check({tag, "_hi"}, num_hi, ~model_lo(v));
  endtask

  initial begin
    int prev;
    int v;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    set_v(7);

    // Reset asserted between edges takes effect immediately.
    #2 rst_n = 1'b0;
    #1;
    check("rst_immediate_lo", num_lo, 14'h3FFF);
    check("rst_immediate_hi", num_hi, 14'h0000);

    // Clock edges while held in reset keep the display off.
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_lo", num_lo, 14'h3FFF);
    check("rst_hold_hi", num_hi, 14'h0000);

    // First edge after release loads the conversion of v = 7.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_lo", num_lo, model_lo(7));
    check("post_rst_hi", num_hi, ~model_lo(7));

    // Sweep every code, one per cycle.
    prev = 7;
    for (int i = 0; i < 16; i++) begin
      apply(i, model_lo(prev), $sformatf("sweep%0d", i));
      prev = i;
    end
    check("lit_v15", num_lo, 14'h3C92);

    // 9 -> 10 boundary: both digits change on the same edge.
    apply(9, model_lo(prev), "bnd9");
    apply(10, model_lo(9), "bnd10");
    check("lit_v10", num_lo, 14'h3CC0);
    prev = 10;

    // Random values, one per cycle.
    for (int i = 0; i < 40; i++) begin
      v = int'($urandom_range(0, 15));
      apply(v, model_lo(prev), $sformatf("rand%0d_v%0d", i, v));
      prev = v;
    end

    // Reset pulsed between edges while v = 13, then released.
    @(negedge clk);
    set_v(13);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_lo", num_lo, 14'h3FFF);
    check("midrst_hi", num_hi, 14'h0000);
    #1 rst_n = 1'b1;
    #1;
    check("midrst_rel_lo", num_lo, 14'h3FFF);
    @(posedge clk);
    #1;
    check("midrst_edge_lo", num_lo, model_lo(13));
    check("midrst_edge_hi", num_hi, ~model_lo(13));
    check("lit_v13", num_lo, 14'h3CB0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
